// File: rtl/caf_pkg.sv
// Shared definitions for the CAF lag sweep: sequencer state encoding and
// magnitude-width helper.
package caf_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } caf_state_e;

    // One extra bit so |i|+|q| of two most-negative inputs still fits.
    function automatic int mag_width(input int i_bits, input int q_bits);
        return ((i_bits > q_bits) ? i_bits : q_bits) + 1;
    endfunction

endpackage

// File: rtl/caf_lag_sched_if.sv
// Link between the lag sequencer, the window buffers and the dot-product unit.
interface caf_lag_sched_if #(
    parameter int i_bits   = 24,
    parameter int q_bits   = 24,
    parameter int lag_bits = 10
);
    logic [lag_bits-1:0]      lag_addr;
    logic                     issue_valid;
    logic                     prod_tready;
    logic                     prod_tvalid;
    logic signed [i_bits-1:0] prod_i;
    logic signed [q_bits-1:0] prod_q;

    modport master (
        output lag_addr, issue_valid, prod_tready,
        input  prod_tvalid, prod_i, prod_q
    );

    modport slave (
        input  lag_addr, issue_valid, prod_tready,
        output prod_tvalid, prod_i, prod_q
    );
endinterface

// File: rtl/cpx_mag_l1.sv
// Combinational L1 magnitude |re|+|im| of a signed complex sample, sized so the
// most-negative inputs never wrap.
module cpx_mag_l1
    import caf_pkg::*;
#(
    parameter int i_bits = 24,
    parameter int q_bits = 24
) (
    input  logic signed [i_bits-1:0]             re,
    input  logic signed [q_bits-1:0]             im,
    output logic [mag_width(i_bits, q_bits)-1:0] mag
);
    localparam int MW = mag_width(i_bits, q_bits);

    logic signed [MW-1:0] re_ext_s;
    logic signed [MW-1:0] im_ext_s;
    logic [MW-1:0]        re_abs_s;
    logic [MW-1:0]        im_abs_s;

    // Sign-extend before negating so -(-2^(w-1)) is representable.
    always_comb begin
        re_ext_s = {{(MW - i_bits){re[i_bits-1]}}, re};
        im_ext_s = {{(MW - q_bits){im[q_bits-1]}}, im};
        if (re_ext_s[MW-1]) begin
            re_abs_s = -re_ext_s;
        end else begin
            re_abs_s = re_ext_s;
        end
        if (im_ext_s[MW-1]) begin
            im_abs_s = -im_ext_s;
        end else begin
            im_abs_s = im_ext_s;
        end
        mag = re_abs_s + im_abs_s;
    end
endmodule

// File: rtl/caf_lag_sched.sv
// Lag sweep sequencer: issues one dot-product request per lag, waits for the
// product and keeps the lag with the largest L1 magnitude.
module caf_lag_sched
    import caf_pkg::*;
#(
    parameter int i_bits   = 24,
    parameter int q_bits   = 24,
    parameter int lag_bits = 10,
    parameter int timeout  = 64
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 start,
    input  logic [lag_bits-1:0]                  n_lags,
    output logic                                 busy,
    output logic                                 done,
    output logic                                 error,
    output logic [lag_bits-1:0]                  peak_lag,
    output logic [mag_width(i_bits, q_bits)-1:0] peak_mag,
    caf_lag_sched_if.master                      dot
);
    localparam int MW = mag_width(i_bits, q_bits);
    localparam int TW = $clog2(timeout + 1);

    caf_state_e          state_r;
    caf_state_e          state_s;
    logic [lag_bits-1:0] k_r;
    logic [lag_bits-1:0] n_lags_r;
    logic [lag_bits-1:0] peak_lag_r;
    logic [MW-1:0]       peak_mag_r;
    logic [MW-1:0]       mag_s;
    logic [TW-1:0]       wait_cnt_r;
    logic                busy_r;
    logic                done_r;
    logic                error_r;
    logic                issue_valid_r;
    logic                prod_tready_r;
    logic                accept_s;
    logic                prod_hit_s;
    logic                last_s;
    logic                expire_s;

    cpx_mag_l1 #(
        .i_bits (i_bits),
        .q_bits (q_bits)
    ) u_mag (
        .re  (dot.prod_i),
        .im  (dot.prod_q),
        .mag (mag_s)
    );

    // Events that drive the sweep; a product wins over an expiring wait.
    always_comb begin
        accept_s   = (state_r == ST_IDLE) && start;
        prod_hit_s = (state_r == ST_WAIT) && dot.prod_tvalid;
        last_s     = (k_r == (n_lags_r - lag_bits'(1)));
        expire_s   = (state_r == ST_WAIT) && !dot.prod_tvalid &&
                     (wait_cnt_r == TW'(timeout - 1));
    end

    // Next-state decode.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    if (n_lags == lag_bits'(0)) begin
                        state_s = ST_DONE;
                    end else begin
                        state_s = ST_ISSUE;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ISSUE: state_s = ST_WAIT;
            ST_WAIT: begin
                if (prod_hit_s) begin
                    if (last_s) begin
                        state_s = ST_DONE;
                    end else begin
                        state_s = ST_ISSUE;
                    end
                end else if (expire_s) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_DONE: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // State register and outputs decoded from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= ST_IDLE;
            busy_r        <= 1'b0;
            issue_valid_r <= 1'b0;
            prod_tready_r <= 1'b0;
            done_r        <= 1'b0;
        end else begin
            state_r       <= state_s;
            busy_r        <= (state_s != ST_IDLE);
            issue_valid_r <= (state_s == ST_ISSUE);
            prod_tready_r <= (state_s == ST_ISSUE) || (state_s == ST_WAIT);
            done_r        <= (state_s == ST_DONE);
        end
    end

    // Per-lag wait counter, zero on every entry to WAIT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt_r <= TW'(0);
        end else if (state_r == ST_WAIT) begin
            wait_cnt_r <= wait_cnt_r + TW'(1);
        end else begin
            wait_cnt_r <= TW'(0);
        end
    end

    // Lag index, peak tracking and sticky timeout flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            k_r        <= lag_bits'(0);
            n_lags_r   <= lag_bits'(0);
            peak_lag_r <= lag_bits'(0);
            peak_mag_r <= MW'(0);
            error_r    <= 1'b0;
        end else if (accept_s) begin
            k_r        <= lag_bits'(0);
            n_lags_r   <= n_lags;
            peak_lag_r <= lag_bits'(0);
            peak_mag_r <= MW'(0);
            error_r    <= 1'b0;
        end else if (prod_hit_s) begin
            if (mag_s > peak_mag_r) begin
                peak_lag_r <= k_r;
                peak_mag_r <= mag_s;
            end else begin
                peak_mag_r <= peak_mag_r;
            end
            if (!last_s) begin
                k_r <= k_r + lag_bits'(1);
            end else begin
                k_r <= k_r;
            end
        end else if (expire_s) begin
            error_r <= 1'b1;
        end else begin
            error_r <= error_r;
        end
    end

    assign busy            = busy_r;
    assign done            = done_r;
    assign error           = error_r;
    assign peak_lag        = peak_lag_r;
    assign peak_mag        = peak_mag_r;
    assign dot.lag_addr    = k_r;
    assign dot.issue_valid = issue_valid_r;
    assign dot.prod_tready = prod_tready_r;
endmodule

// File: tb/tb_caf_lag_sched.sv
// Bench for caf_lag_sched: table vectors, hand sequences for corner cases and
// randomized sweeps scored against a max-then-first-index peak model.
module tb_caf_lag_sched;
    localparam int IB = 24;
    localparam int QB = 24;
    localparam int LB = 10;
    localparam int TO = 64;
    localparam int MW = 25;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [LB-1:0] n_lags;
    logic          busy;
    logic          done;
    logic          error;
    logic [LB-1:0] peak_lag;
    logic [MW-1:0] peak_mag;

    int pass_cnt = 0;
    int total_cnt = 0;

    caf_lag_sched_if #(.i_bits(IB), .q_bits(QB), .lag_bits(LB)) dot_if ();

    caf_lag_sched #(
        .i_bits(IB), .q_bits(QB), .lag_bits(LB), .timeout(TO)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .n_lags(n_lags),
        .busy(busy), .done(done), .error(error),
        .peak_lag(peak_lag), .peak_mag(peak_mag), .dot(dot_if)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        int               n;
        int               silent;
        logic [3:0][23:0] pi;
        logic [3:0][23:0] pq;
        int               exp_lag;
        longint           exp_mag;
        bit               exp_err;
    } vec_t;

    vec_t vecs[7];
    logic signed [23:0] pi_g[16];
    logic signed [23:0] pq_g[16];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input longint act, input longint exp);
        total_cnt++;
        if (act == exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input int n, input int silent,
                                input int i0, input int q0, input int i1, input int q1,
                                input int i2, input int q2, input int i3, input int q3,
                                input int el, input longint em, input bit ee);
        vec_t v;
        v.n = n;  v.silent = silent;
        v.pi[0] = i0[23:0]; v.pq[0] = q0[23:0];
        v.pi[1] = i1[23:0]; v.pq[1] = q1[23:0];
        v.pi[2] = i2[23:0]; v.pq[2] = q2[23:0];
        v.pi[3] = i3[23:0]; v.pq[3] = q3[23:0];
        v.exp_lag = el; v.exp_mag = em; v.exp_err = ee;
        return v;
    endfunction

    // Peak = largest |i|+|q| among answered lags, earliest index on ties, lag 0 if all zero.
    function automatic void ref_peak(input int cnt, output int lag, output longint mag);
        longint m[16];
        longint mx = 0;
        for (int i = 0; i < cnt; i++) begin
            int a = int'(pi_g[i]);
            int b = int'(pq_g[i]);
            m[i] = longint'((a < 0) ? -a : a) + longint'((b < 0) ? -b : b);
            if (m[i] > mx) mx = m[i];
        end
        lag = 0;
        mag = mx;
        if (mx != 0) begin
            for (int i = cnt - 1; i >= 0; i--) begin
                if (m[i] == mx) lag = i;
            end
        end
    endfunction

    function automatic logic signed [23:0] rnd_sample();
        logic [23:0] r;
        r = 24'($urandom);
        case ($urandom_range(0, 4))
            0: rnd_sample = 24'h800000;
            1: rnd_sample = 24'h7fffff;
            2: rnd_sample = 24'($urandom_range(0, 8)) - 24'd4;
            default: rnd_sample = r;
        endcase
    endfunction

    // Drive one sweep acting as the dot unit; silent >= 0 leaves that lag unanswered.
    task automatic sweep(input int n, input int silent, input int lat_max, input bit noise,
                         input int exp_lag, input longint exp_mag, input bit exp_err);
        int waited;
        int lat;
        start = 1'b1;
        n_lags = n[LB-1:0];
        tick();
        start = 1'b0;
        check("busy_after_start", busy, 1);
        check("error_cleared", error, 0);
        for (int k = 0; k < n; k++) begin
            waited = 0;
            while (!dot_if.issue_valid && waited < 20) begin
                tick();
                waited++;
            end
            check("issue_seen", dot_if.issue_valid, 1);
            if (!dot_if.issue_valid) return;
            check("lag_addr", dot_if.lag_addr, k);
            check("tready_issue", dot_if.prod_tready, 1);
            if (noise) begin
                dot_if.prod_tvalid = 1'b1;
                dot_if.prod_i = 24'h800000;
                dot_if.prod_q = 24'h800000;
            end
            tick();
            dot_if.prod_tvalid = 1'b0;
            check("issue_one_cycle", dot_if.issue_valid, 0);
            if (k == silent) begin
                repeat (TO - 1) tick();
                check("no_early_done", done, 0);
                tick();
                break;
            end
            lat = (lat_max > 0) ? $urandom_range(0, lat_max) : 0;
            for (int j = 0; j < lat; j++) begin
                if (noise && j == 0) begin
                    start = 1'b1;
                    n_lags = 10'd1;
                end
                tick();
                start = 1'b0;
            end
            dot_if.prod_tvalid = 1'b1;
            dot_if.prod_i = pi_g[k];
            dot_if.prod_q = pq_g[k];
            tick();
            dot_if.prod_tvalid = 1'b0;
            dot_if.prod_i = 24'd0;
            dot_if.prod_q = 24'd0;
        end
        check("done_pulse", done, 1);
        check("peak_lag", peak_lag, exp_lag);
        check("peak_mag", peak_mag, exp_mag);
        check("error_flag", error, exp_err);
        tick();
        check("done_drop", done, 0);
        check("busy_drop", busy, 0);
        check("peak_mag_hold", peak_mag, exp_mag);
        check("error_hold", error, exp_err);
    endtask

    task automatic load_vec(input int v);
        for (int j = 0; j < 4; j++) begin
            pi_g[j] = vecs[v].pi[j];
            pq_g[j] = vecs[v].pq[j];
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_error"}, error, 0);
        check({tag, "_issue"}, dot_if.issue_valid, 0);
        check({tag, "_tready"}, dot_if.prod_tready, 0);
        check({tag, "_lag_addr"}, dot_if.lag_addr, 0);
        check({tag, "_peak_lag"}, peak_lag, 0);
        check({tag, "_peak_mag"}, peak_mag, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int el;
        longint em;
        int n;
        int silent;

        vecs[0] = mk(4, -1, 10, 0, 20, 10, 0, -30, 5, 0, 1, 30, 1'b0);
        vecs[1] = mk(1, -1, -8388608, -8388608, 0, 0, 0, 0, 0, 0, 0, 64'd16777216, 1'b0);
        vecs[2] = mk(3, -1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1'b0);
        vecs[3] = mk(4, 2, 3, 4, -7, 1, 900, 900, 900, 900, 1, 8, 1'b1);
        vecs[4] = mk(4, -1, 1, 1, 2, 2, -3, 3, 0, 7, 3, 7, 1'b0);
        vecs[5] = mk(2, -1, 8388607, 8388607, -8388608, 0, 0, 0, 0, 0, 0, 64'd16777214, 1'b0);
        vecs[6] = mk(3, -1, 0, -5, 5, 0, -2, -3, 0, 0, 0, 5, 1'b0);

        rst = 1'b1;
        start = 1'b0;
        n_lags = 10'd0;
        dot_if.prod_tvalid = 1'b0;
        dot_if.prod_i = 24'd0;
        dot_if.prod_q = 24'd0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b0;
        tick();

        for (int v = 0; v < 7; v++) begin
            load_vec(v);
            sweep(vecs[v].n, vecs[v].silent, 2, 1'b0,
                  vecs[v].exp_lag, vecs[v].exp_mag, vecs[v].exp_err);
        end

        // Reset during WAIT of lag 1.
        pi_g[0] = 24'sd100;
        pq_g[0] = 24'sd0;
        start = 1'b1;
        n_lags = 10'd3;
        tick();
        start = 1'b0;
        tick();
        dot_if.prod_tvalid = 1'b1;
        dot_if.prod_i = pi_g[0];
        dot_if.prod_q = pq_g[0];
        tick();
        dot_if.prod_tvalid = 1'b0;
        check("rst_pre_lag", dot_if.lag_addr, 1);
        check("rst_pre_peak", peak_mag, 100);
        tick();
        #2 rst = 1'b1;
        #1;
        check_all_zero("midrst");
        #1 rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            check("midrst_no_done", done, 0);
        end

        load_vec(0);
        sweep(4, -1, 1, 1'b0, 1, 30, 1'b0);

        // Products while idle must not disturb the held peak.
        dot_if.prod_tvalid = 1'b1;
        dot_if.prod_i = 24'h800000;
        dot_if.prod_q = 24'h800000;
        repeat (3) tick();
        dot_if.prod_tvalid = 1'b0;
        tick();
        check("idle_tvalid_mag", peak_mag, 30);
        check("idle_tvalid_lag", peak_lag, 1);
        check("idle_tvalid_busy", busy, 0);

        // Zero-lag sweep completes immediately with no request.
        start = 1'b1;
        n_lags = 10'd0;
        tick();
        start = 1'b0;
        check("zero_done", done, 1);
        check("zero_busy", busy, 1);
        check("zero_issue", dot_if.issue_valid, 0);
        check("zero_peak_mag", peak_mag, 0);
        check("zero_peak_lag", peak_lag, 0);
        tick();
        check("zero_done_drop", done, 0);
        check("zero_busy_drop", busy, 0);
        check("zero_issue_after", dot_if.issue_valid, 0);

        for (int r = 0; r < 12; r++) begin
            n = $urandom_range(1, 8);
            silent = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, n - 1)) : -1;
            for (int j = 0; j < n; j++) begin
                pi_g[j] = rnd_sample();
                pq_g[j] = rnd_sample();
            end
            ref_peak((silent >= 0) ? silent : n, el, em);
            sweep(n, silent, 3, 1'b1, el, em, silent >= 0);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
